// File: rtl/decim_pkg.sv
// rtl/decim_pkg.sv - state encoding and default ratio constants shared by the decimator controller
package decim_pkg;

  // Controller states; the numeric values are visible on the STATE port.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } decim_state_e;

  // Default 64 -> 44 rate change expressed as 11 outputs per 16 input bits.
  localparam int DECIM_NUM    = 11;
  localparam int DECIM_DEN    = 16;

  // Filter settling outputs thrown away after every start.
  localparam int DECIM_WARMUP = 32;

  // Accumulator width wide enough that acc + NUM (acc < DEN, NUM <= DEN) never wraps.
  function automatic int decim_acc_width(input int den);
    return $clog2(den) + 1;
  endfunction

endpackage

// File: rtl/decim_phase_acc.sv
// rtl/decim_phase_acc.sv - fractional phase accumulator issuing NUM strobes per DEN advances
module decim_phase_acc
  import decim_pkg::*;
#(
  parameter int NUM = DECIM_NUM,
  parameter int DEN = DECIM_DEN
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic adv,
  output logic stb
);

  localparam int              ACCW  = decim_acc_width(DEN);
  localparam logic [ACCW-1:0] NUM_W = ACCW'(NUM);
  localparam logic [ACCW-1:0] DEN_W = ACCW'(DEN);

  logic [ACCW-1:0] acc_q;
  logic [ACCW-1:0] acc_d;
  logic [ACCW-1:0] sum;
  logic            stb_q;
  logic            stb_d;

  // Step the phase by NUM on every advance; each wrap past DEN is one output sample due.
  always_comb begin
    sum   = acc_q + NUM_W;
    acc_d = acc_q;
    stb_d = 1'b0;
    if (clr) begin
      acc_d = '0;
    end else if (adv) begin
      if (sum >= DEN_W) begin
        acc_d = sum - DEN_W;
        stb_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  // Phase and strobe registers; the strobe lands in the cycle after the advancing bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q <= '0;
      stb_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      stb_q <= stb_d;
    end
  end

  assign stb = stb_q;

endmodule

// File: rtl/decim_ctrl.sv
// rtl/decim_ctrl.sv - Filter decimator sequencer: FSM, warm-up discard, output register; DECIM_STATS_EN adds DROP_CNT
module decim_ctrl
  import decim_pkg::*;
#(
  parameter int NUM    = DECIM_NUM,
  parameter int DEN    = DECIM_DEN,
  parameter int WARMUP = DECIM_WARMUP,
  parameter int DW     = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          BIT_VALID,
  input  logic [DW-1:0] FILT_OUT,
  output logic          FILT_CE,
  output logic          DEC_STB,
  output logic [DW-1:0] OUT_DATA,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic          OVF,
  input  logic          CLR_OVF,
`ifdef DECIM_STATS_EN
  output logic [7:0]    DROP_CNT,
`endif
  output logic [1:0]    STATE
);

  // Counter must hold the value WARMUP itself, and stay at least one bit wide when WARMUP is 0.
  localparam int WCW = $clog2(WARMUP + 2);

  decim_state_e   state_q;
  decim_state_e   state_d;
  logic [WCW-1:0] warm_cnt_q;
  logic [WCW-1:0] warm_cnt_d;

  logic           filt_ce_q;
  logic           cap_pend_q;
  logic           stb;
  logic           adv;
  logic           clr;

  logic           cap_run;
  logic           cap_warm;
  logic           warm_last;
  logic           drop;

  logic [DW-1:0]  out_data_q;
  logic [DW-1:0]  out_data_d;
  logic           out_valid_q;
  logic           out_valid_d;
  logic           ovf_q;
  logic           ovf_d;

  // A bit only advances the filter while running and still enabled this cycle, so
  // FILT_CE is already low in the first IDLE cycle after EN falls.
  assign adv = EN && BIT_VALID && (state_q != ST_IDLE);
  assign clr = !EN || (state_q == ST_IDLE);

  decim_phase_acc #(
    .NUM (NUM),
    .DEN (DEN)
  ) u_acc (
    .CLK (CLK),
    .RST (RST),
    .clr (clr),
    .adv (adv),
    .stb (stb)
  );

  // A capture arriving while EN is low or in IDLE is the tail of a stopped run and is dropped silently.
  assign cap_run   = cap_pend_q && EN && (state_q == ST_RUN);
  assign cap_warm  = cap_pend_q && EN && (state_q == ST_WARMUP);
  assign warm_last = cap_warm && ((32'(warm_cnt_q) + 32'd1) == 32'(WARMUP));

  // Next state and warm-up count; EN low forces IDLE from any state.
  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    if (!EN) begin
      state_d    = ST_IDLE;
      warm_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          warm_cnt_d = '0;
          state_d    = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
        end
        ST_WARMUP: begin
          if (cap_warm) begin
            warm_cnt_d = warm_cnt_q + WCW'(1);
            if (warm_last) begin
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d    = ST_IDLE;
          warm_cnt_d = '0;
        end
      endcase
    end
  end

  // State register and warm-up counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      warm_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
    end
  end

  // Filter enable follows the accepted bit by one cycle; the strobe is delayed once more to
  // mark the cycle in which FILT_OUT carries the computed sample.
  always_ff @(posedge CLK) begin
    if (RST) begin
      filt_ce_q  <= 1'b0;
      cap_pend_q <= 1'b0;
    end else begin
      filt_ce_q  <= adv;
      cap_pend_q <= stb;
    end
  end

  // Single-entry output slot: a simultaneous consume frees room for the new sample,
  // otherwise a full slot keeps its old value and the newcomer is dropped.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    drop        = 1'b0;
    if (cap_run) begin
      if (!out_valid_q || OUT_READY) begin
        out_data_d  = FILT_OUT;
        out_valid_d = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end else if (out_valid_q && OUT_READY) begin
      out_valid_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end else if (CLR_OVF) begin
      ovf_d = 1'b0;
    end
  end

  // Output slot and sticky overflow flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef DECIM_STATS_EN
  logic [7:0] drop_cnt_q;
  logic [7:0] drop_cnt_d;

  // Saturating drop counter; a drop in the clearing cycle still counts.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (CLR_OVF) begin
      drop_cnt_d = 8'd0;
    end
    if (drop && (drop_cnt_d != 8'hFF)) begin
      drop_cnt_d = drop_cnt_d + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign DROP_CNT = drop_cnt_q;
`endif

  assign FILT_CE   = filt_ce_q;
  assign DEC_STB   = stb;
  assign OUT_DATA  = out_data_q;
  assign OUT_VALID = out_valid_q;
  assign OVF       = ovf_q;
  assign STATE     = state_q;

endmodule

// File: tb/tb_decim_ctrl.sv
// tb/tb_decim_ctrl.sv - self-checking bench for decim_ctrl: vector table, corner sequences, random vs model
module tb_decim_ctrl;

  localparam int NUM    = 11;
  localparam int DEN    = 16;
  localparam int WARMUP = 4;
  localparam int DW     = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          EN;
  logic          BIT_VALID;
  logic [DW-1:0] FILT_OUT;
  logic          FILT_CE;
  logic          DEC_STB;
  logic [DW-1:0] OUT_DATA;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic          OVF;
  logic          CLR_OVF;
  logic [1:0]    STATE;
`ifdef DECIM_STATS_EN
  logic [7:0]    DROP_CNT;
`endif

  decim_ctrl #(
    .NUM    (NUM),
    .DEN    (DEN),
    .WARMUP (WARMUP),
    .DW     (DW)
  ) u_dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .BIT_VALID (BIT_VALID),
    .FILT_OUT  (FILT_OUT),
    .FILT_CE   (FILT_CE),
    .DEC_STB   (DEC_STB),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OVF       (OVF),
    .CLR_OVF   (CLR_OVF),
`ifdef DECIM_STATS_EN
    .DROP_CNT  (DROP_CNT),
`endif
    .STATE     (STATE)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       en;
    logic       bv;
    logic       exp_ce;
    logic       exp_stb;
    logic [1:0] exp_st;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic ce, input logic stb, input logic [1:0] st,
                                     input logic v, input logic [7:0] d, input logic o);
    return 32'({ce, stb, st, v, d, o});
  endfunction

  function automatic logic [31:0] dut_pk();
    return pk(FILT_CE, DEC_STB, STATE, OUT_VALID, OUT_DATA, OVF);
  endfunction

  // Feed bits until a strobe appears, then present d on FILT_OUT in the capture cycle,
  // with OUT_READY = rdy only in that cycle.
  task automatic capture(input logic [7:0] d, input logic rdy);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 2 * DEN && !got; i++) begin
      BIT_VALID = 1'b1;
      tick();
      BIT_VALID = 1'b0;
      got = DEC_STB;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL capture_timeout: DEC_STB got 0 expected 1");
    end
    tick();
    FILT_OUT  = d;
    OUT_READY = rdy;
    tick();
    FILT_OUT  = '0;
    OUT_READY = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
  endtask

  // Watchdog against a stalled run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_stb;
    int n_smp;
    int m_st, m_k, m_w;
    logic m_ce, m_stb, m_stb_prev, m_valid, m_ovf, n_ce, n_stb_b, cap, dropped;
    logic [7:0] m_data;
    logic en, bv, rdy, clr;
    logic [7:0] fo;
`ifdef DECIM_STATS_EN
    int m_drop;
`endif

    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd1};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 2'd1};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd1};

    RST       = 1'b1;
    EN        = 1'b0;
    BIT_VALID = 1'b0;
    FILT_OUT  = '0;
    OUT_READY = 1'b0;
    CLR_OVF   = 1'b0;
    tick();
    tick();
    check("reset_state", dut_pk(), pk(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0));
`ifdef DECIM_STATS_EN
    check("reset_drop_cnt", 32'(DROP_CNT), 32'd0);
`endif
    RST = 1'b0;

    // Vector table: start-up, strobe pattern from phase 0, disable and restart.
    for (int i = 0; i < 10; i++) begin
      EN        = vecs[i].en;
      BIT_VALID = vecs[i].bv;
      tick();
      check($sformatf("vec%0d", i), dut_pk(),
            pk(vecs[i].exp_ce, vecs[i].exp_stb, vecs[i].exp_st, 1'b0, 8'h00, 1'b0));
    end
    BIT_VALID = 1'b0;

    // Ratio and warm-up over 32 continuous bits.
    do_reset();
    EN        = 1'b1;
    OUT_READY = 1'b1;
    tick();
    n_stb = 0;
    n_smp = 0;
    for (int i = 0; i < 32; i++) begin
      BIT_VALID = 1'b1;
      FILT_OUT  = 8'($urandom);
      tick();
      if (DEC_STB) n_stb++;
      if (OUT_VALID && OUT_READY) n_smp++;
    end
    check("ratio_acc_zero", 32'(u_dut.u_acc.acc_q), 32'd0);
    BIT_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      FILT_OUT = 8'($urandom);
      tick();
      if (DEC_STB) n_stb++;
      if (OUT_VALID && OUT_READY) n_smp++;
    end
    check("ratio_strobes", 32'(n_stb), 32'd22);
    check("ratio_samples", 32'(n_smp), 32'd18);
    check("ratio_state_run", 32'(STATE), 32'd2);

    // Latency: strobe-producing bit in cycle t -> DEC_STB t+1 -> sample visible t+3.
    BIT_VALID = 1'b1;
    tick();
    check("lat_bit1_nostb", 32'(DEC_STB), 32'd0);
    BIT_VALID = 1'b0;
    tick();
    BIT_VALID = 1'b1;
    tick();
    check("lat_stb_t1", 32'(DEC_STB), 32'd1);
    BIT_VALID = 1'b0;
    FILT_OUT  = 8'h00;
    tick();
    check("lat_t2_empty", 32'(OUT_VALID), 32'd0);
    FILT_OUT = 8'hA5;
    tick();
    check("lat_t3", 32'({OUT_VALID, OUT_DATA}), 32'({1'b1, 8'hA5}));
    FILT_OUT = 8'h00;
    tick();
    OUT_READY = 1'b0;
    check("lat_consumed", 32'(OUT_VALID), 32'd0);

    // Backpressure, drop and overflow clear.
    capture(8'h11, 1'b0);
    check("bp_first", 32'({OUT_VALID, OUT_DATA, OVF}), 32'({1'b1, 8'h11, 1'b0}));
    capture(8'h22, 1'b0);
    check("bp_hold", 32'({OUT_VALID, OUT_DATA, OVF}), 32'({1'b1, 8'h11, 1'b1}));
`ifdef DECIM_STATS_EN
    check("bp_drop_cnt", 32'(DROP_CNT), 32'd1);
`endif
    CLR_OVF = 1'b1;
    tick();
    CLR_OVF = 1'b0;
    check("bp_clr", 32'({OUT_VALID, OUT_DATA, OVF}), 32'({1'b1, 8'h11, 1'b0}));
`ifdef DECIM_STATS_EN
    check("bp_clr_cnt", 32'(DROP_CNT), 32'd0);
`endif

    // Consume and load in the same cycle.
    capture(8'h33, 1'b1);
    check("simul_load", 32'({OUT_VALID, OUT_DATA, OVF}), 32'({1'b1, 8'h33, 1'b0}));

    // Reset in RUN with a held sample and OVF set.
    capture(8'h44, 1'b0);
    check("pre_rst", 32'({OUT_VALID, OUT_DATA, OVF}), 32'({1'b1, 8'h33, 1'b1}));
    do_reset();
    check("mid_rst", dut_pk(), pk(1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 1'b0));
`ifdef DECIM_STATS_EN
    check("mid_rst_cnt", 32'(DROP_CNT), 32'd0);
`endif

    // Disable after 7 bits, then restart from phase 0 and an empty warm-up count.
    tick();
    for (int i = 0; i < 7; i++) begin
      BIT_VALID = 1'b1;
      tick();
    end
    EN = 1'b0;
    tick();
    check("dis_idle", 32'({STATE, FILT_CE, u_dut.u_acc.acc_q}), 32'd0);
    EN        = 1'b1;
    BIT_VALID = 1'b0;
    tick();
    check("reen_warm", 32'({STATE, u_dut.warm_cnt_q}), 32'({2'd1, 3'd0}));
    BIT_VALID = 1'b1;
    tick();
    check("reen_bit1", 32'({FILT_CE, DEC_STB}), 32'({1'b1, 1'b0}));
    tick();
    check("reen_bit2", 32'({FILT_CE, DEC_STB}), 32'({1'b1, 1'b1}));
    BIT_VALID = 1'b0;

    // Randomized run against a reference model built from the rate rules.
    do_reset();
    m_st = 0; m_k = 0; m_w = 0;
    m_ce = 0; m_stb = 0; m_stb_prev = 0; m_valid = 0; m_ovf = 0; m_data = 8'h00;
`ifdef DECIM_STATS_EN
    m_drop = 0;
`endif
    for (int c = 0; c < 800; c++) begin
      en  = ($urandom_range(0, 59) != 0);
      bv  = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 5);
      clr = ($urandom_range(0, 19) == 0);
      fo  = 8'($urandom);

      cap     = m_stb_prev;
      n_ce    = en && bv && (m_st != 0);
      n_stb_b = 1'b0;
      if (n_ce) begin
        m_k++;
        n_stb_b = ((m_k * NUM) / DEN) != (((m_k - 1) * NUM) / DEN);
      end
      dropped = 1'b0;
      if (cap && en && m_st == 2) begin
        if (!m_valid || rdy) begin
          m_data  = fo;
          m_valid = 1'b1;
        end else begin
          dropped = 1'b1;
        end
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
      if (dropped) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
`ifdef DECIM_STATS_EN
      if (clr) m_drop = 0;
      if (dropped && m_drop < 255) m_drop++;
`endif
      if (cap && en && m_st == 1) m_w++;
      if (!en) begin
        m_st = 0; m_k = 0; m_w = 0;
      end else if (m_st == 0) begin
        m_st = (WARMUP == 0) ? 2 : 1;
      end else if (m_st == 1 && m_w == WARMUP) begin
        m_st = 2;
      end
      m_stb_prev = m_stb;
      m_stb      = n_stb_b;
      m_ce       = n_ce;

      EN        = en;
      BIT_VALID = bv;
      OUT_READY = rdy;
      CLR_OVF   = clr;
      FILT_OUT  = fo;
      tick();
      check($sformatf("rand%0d", c), dut_pk(), pk(m_ce, m_stb, 2'(m_st), m_valid, m_data, m_ovf));
`ifdef DECIM_STATS_EN
      check($sformatf("rand_cnt%0d", c), 32'(DROP_CNT), 32'(m_drop));
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decim_ctrl.md
# decim_ctrl

Sequencing controller for the 1-bit-in / 8-bit-out `Filter` decimator. It accepts the serial bitstream cadence and issues the filter's clock-enable and the fractional decimation strobes for the 64→44 (16/11) rate change. It discards the filter's settling outputs and presents decimated samples on a valid/ready port with overflow detection. It sits between the bitstream front end and the downstream sample consumer.

## Interface
- `NUM`, 11, output samples per `DEN` input bits
- `DEN`, 16, input bits per `NUM` output samples; `NUM` must be between 1 and `DEN`
- `WARMUP`, 32, number of initial decimated samples discarded after each start
- `DW`, 8, sample width; matches `Filter` `OUT`
- `CLK`  in  1  clock; all logic on rising edge
- `RST`  in  1  synchronous, active-high reset
- `EN`  in  1  run enable; level-sensitive
- `BIT_VALID`  in  1  one input bit is presented to the filter this cycle
- `FILT_OUT`  in  DW  filter output; valid the cycle after `DEC_STB`
- `FILT_CE`  out  1  filter clock-enable; advances filter by one bit
- `DEC_STB`  out  1  decimation strobe; filter computes an output sample
- `OUT_DATA`  out  DW  decimated sample
- `OUT_VALID`  out  1  `OUT_DATA` holds an unconsumed sample
- `OUT_READY`  in  1  consumer accepts when `OUT_VALID` and `OUT_READY` are both high
- `OVF`  out  1  sticky; a sample was dropped
- `CLR_OVF`  in  1  clears `OVF`
- `STATE`  out  2  current state: 0 = IDLE, 1 = WARMUP, 2 = RUN

## Operation
- **States**
  - IDLE → WARMUP when `EN`=1.
  - WARMUP → RUN when the warm-up count reaches `WARMUP`. If `WARMUP`=0, go directly IDLE → RUN.
  - Any state → IDLE when `EN`=0 (next edge).
- **Phase accumulator** `acc`
  - Range 0..`DEN`-1. Width is clog2(`DEN`)+1 bits so that `acc`+`NUM` does not overflow.
  - On each `BIT_VALID` while not IDLE: if `acc`+`NUM` ≥ `DEN`, load `acc`+`NUM`-`DEN` and raise the strobe. Otherwise load `acc`+`NUM`.
  - This yields exactly `NUM` strobes per `DEN` bits, with `acc` returning to its start value.
- **IDLE**
  - `acc` = 0 and the warm-up counter = 0.
  - `FILT_CE` = 0 and `DEC_STB` = 0. `BIT_VALID` is ignored.
- **WARMUP**
  - Strobes are issued normally.
  - Each captured `FILT_OUT` increments the warm-up counter and is discarded.
- **RUN**
  - Each captured `FILT_OUT` is offered to the output register.
- **Output register** (single entry)
  - Empty: load the sample and set `OUT_VALID`.
  - Full and `OUT_READY`=1 in the same cycle: the old sample is consumed and the new one is loaded; no drop.
  - Full and `OUT_READY`=0: keep the old sample, drop the new one, set `OVF`.
- **`OVF` clearing**
  - `CLR_OVF` clears `OVF`.
  - If a drop occurs in the same cycle, the set wins.
- **Leaving RUN/WARMUP** (`EN` falls)
  - A strobe already in flight is still captured by the pipeline but discarded.
  - A pending `OUT_DATA` stays valid until consumed.
- **Reset values**
  - State IDLE, `acc` = 0, `FILT_CE` = 0, `DEC_STB` = 0.
  - `OUT_DATA` = 0, `OUT_VALID` = 0, `OVF` = 0, `STATE` = 0.

## Timing
- `BIT_VALID` in cycle t → `FILT_CE` (and `DEC_STB` if due) registered, high in cycle t+1.
- `DEC_STB` in cycle t+1 → `FILT_OUT` sampled at the end of cycle t+2 → `OUT_VALID` high from cycle t+3. Total latency: 3 cycles.
- Back-to-back `BIT_VALID` is supported at full rate.
- `OUT_VALID`/`OUT_DATA` remain stable while `OUT_READY`=0 (no drop of the held value).
- `EN` sampled 0 in cycle t → `STATE` = IDLE and `FILT_CE` = 0 from cycle t+1.
- `RST` mid-stream overrides everything in the same edge, including a pending capture.

## Configuration
- `DECIM_STATS_EN` defined:
  - Adds output port `DROP_CNT` (8 bits, saturating at 255).
  - `DROP_CNT` increments on every dropped sample.
  - `DROP_CNT` is cleared by `RST` and by `CLR_OVF`.
- `DECIM_STATS_EN` undefined:
  - `DROP_CNT` port and its logic are absent.
  - `OVF` behaviour is unchanged.

## Structure
- Package `decim_pkg` holds:
  - State encoding constants (IDLE/WARMUP/RUN).
  - Default ratio constants `DECIM_NUM` = 11 and `DECIM_DEN` = 16.
  - Default `DECIM_WARMUP` = 32.
- Sub-module `decim_phase_acc`:
  - Ports: `CLK`, `RST`, `clr`, `adv` in; `stb` out.
  - Contains the phase accumulator and strobe generation.
  - `decim_ctrl` holds the FSM, warm-up counter, capture pipeline and output register.

## Test plan
- **Ratio and warm-up:** `NUM`=11, `DEN`=16, `WARMUP`=4; `EN`=1, `BIT_VALID` continuous for 32 bits, `OUT_READY`=1 → exactly 22 `DEC_STB` pulses, 18 `OUT_VALID` samples, `acc`=0 after bit 32.
- **Latency:** single `BIT_VALID` that triggers a strobe in cycle t, `FILT_OUT`=8'hA5 → `DEC_STB` at t+1, `OUT_DATA`=8'hA5 with `OUT_VALID` at t+3.
- **Backpressure:** RUN with `OUT_READY`=0 across two captures (8'h11, then 8'h22) → `OUT_DATA` stays 8'h11, `OVF`=1, `DROP_CNT`=1 with the macro defined; `CLR_OVF` → `OVF`=0.
- **Simultaneous consume and load:** `OUT_VALID`=1, `OUT_READY`=1 in the capture cycle of 8'h33 → 8'h33 loaded, `OVF` stays 0.
- **Disable mid-stream:** `EN` dropped after 7 bits → `STATE`=0 next cycle, `FILT_CE`=0, `acc`=0. Re-enable → warm-up restarts at 0 and the strobe pattern restarts from phase 0.
- **Reset mid-operation:** `RST` pulsed during RUN with `OUT_VALID`=1 and `OVF`=1 → all outputs at reset values on the next cycle.
